// File: rtl/tlc_vehicle_detector.sv
// Conditions one raw inductive-loop input into a clean, extended vehicle-detect call,
// with a saturating vehicle counter and a stuck-loop fail-safe.
module tlc_vehicle_detector #(
   parameter int DEB_CYC   = 3,
   parameter int HOLD_CYC  = 10,
   parameter int STUCK_CYC = 200,
   parameter int CNT_W     = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_loop,
   input  logic             i_count_clr,
   output logic             o_vd,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_veh_count
);

   localparam int DEB_W  = $clog2(DEB_CYC + 1);
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int ON_W   = $clog2(STUCK_CYC + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(STUCK_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUAL    = 3'd1,
      ST_PRESENT = 3'd2,
      ST_HOLD    = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   state_t              state, state_n;
   logic                loop_m, loop_s;
   logic [DEB_W-1:0]    deb_cnt, deb_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;
   logic [ON_W-1:0]     on_cnt, on_n;
   logic                veh_inc;
   logic [CNT_W-1:0]    cnt_n;
   logic                vd_n, fault_n;

   // Two-flop synchroniser; the first flop feeds nothing but the second.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         loop_m <= 1'b0;
         loop_s <= 1'b0;
      end else begin
         loop_m <= i_loop;
         loop_s <= loop_m;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         on_cnt      <= '0;
         o_vd        <= 1'b0;
         o_fault     <= 1'b0;
         o_veh_count <= '0;
      end else begin
         state       <= state_n;
         deb_cnt     <= deb_n;
         hold_cnt    <= hold_n;
         on_cnt      <= on_n;
         o_vd        <= vd_n;
         o_fault     <= fault_n;
         o_veh_count <= cnt_n;
      end
   end

   // deb_cnt counts samples that disagree with the current state's settled level.
   always_comb begin
      state_n = state;
      deb_n   = deb_cnt;
      hold_n  = hold_cnt;
      on_n    = on_cnt;
      veh_inc = 1'b0;
      case (state)
         ST_IDLE: begin
            deb_n  = '0;
            hold_n = '0;
            on_n   = '0;
            if (loop_s) begin
               if (DEB_CYC == 1) begin
                  state_n = ST_PRESENT;
                  veh_inc = 1'b1;
               end else begin
                  state_n = ST_QUAL;
                  deb_n   = DEB_W'(1);
               end
            end
         end
         ST_QUAL: begin
            if (!loop_s) begin
               state_n = ST_IDLE;
               deb_n   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n = ST_PRESENT;
               deb_n   = '0;
               on_n    = '0;
               veh_inc = 1'b1;
            end else begin
               deb_n = deb_cnt + DEB_W'(1);
            end
         end
         ST_PRESENT: begin
            on_n = on_cnt + ON_W'(1);
            if (on_cnt == ON_LAST) begin
               // Stuck loop wins over a release qualifying on the same cycle.
               state_n = ST_FAULT;
               deb_n   = '0;
               on_n    = '0;
            end else if (!loop_s) begin
               if (deb_cnt == DEB_LAST) begin
                  state_n = ST_HOLD;
                  deb_n   = '0;
                  hold_n  = '0;
               end else begin
                  deb_n = deb_cnt + DEB_W'(1);
               end
            end else begin
               deb_n = '0;
            end
         end
         ST_HOLD: begin
            hold_n = hold_cnt + HOLD_W'(1);
            if (loop_s && (deb_cnt == DEB_LAST)) begin
               // A new vehicle beats the hold timeout on the same cycle.
               state_n = ST_PRESENT;
               deb_n   = '0;
               hold_n  = '0;
               on_n    = '0;
               veh_inc = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_n = ST_IDLE;
               deb_n   = '0;
               hold_n  = '0;
            end else if (loop_s) begin
               deb_n = deb_cnt + DEB_W'(1);
            end else begin
               deb_n = '0;
            end
         end
         ST_FAULT: begin
            on_n = '0;
            if (!loop_s) begin
               if (deb_cnt == DEB_LAST) begin
                  state_n = ST_IDLE;
                  deb_n   = '0;
               end else begin
                  deb_n = deb_cnt + DEB_W'(1);
               end
            end else begin
               deb_n = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            deb_n   = '0;
            hold_n  = '0;
            on_n    = '0;
         end
      endcase
   end

   // Outputs follow the next state so they move on the same edge as the FSM.
   always_comb begin
      vd_n    = (state_n == ST_PRESENT) || (state_n == ST_HOLD) || (state_n == ST_FAULT);
      fault_n = (state_n == ST_FAULT);
   end

   // A clear coinciding with a new vehicle still records that vehicle.
   always_comb begin
      cnt_n = o_veh_count;
      if (i_count_clr) begin
         cnt_n = veh_inc ? CNT_W'(1) : '0;
      end else if (veh_inc && (o_veh_count != CNT_MAX)) begin
         cnt_n = o_veh_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tlc_vehicle_detector.sv
// Directed bench for tlc_vehicle_detector at default parameters: latency, debounce,
// hold extension, stuck-loop fault and counter saturation/clear.
module tb_tlc_vehicle_detector;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_loop;
   logic       i_count_clr;
   logic       o_vd;
   logic       o_fault;
   logic [7:0] o_veh_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       loop;
      logic       clr;
      int         cycles;
      logic       every;
      logic       exp_vd;
      logic       exp_fault;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   tlc_vehicle_detector dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_loop      (i_loop),
      .i_count_clr (i_count_clr),
      .o_vd        (o_vd),
      .o_fault     (o_fault),
      .o_veh_count (o_veh_count)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic loop, input logic clr, input int cycles, input logic every,
                          input logic vd, input logic fault, input logic [7:0] cnt);
      vec_t v;
      v.loop = loop; v.clr = clr; v.cycles = cycles; v.every = every;
      v.exp_vd = vd; v.exp_fault = fault; v.exp_cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic vehicle();
      i_loop = 1'b1;
      repeat (5) tick();
      i_loop = 1'b0;
      repeat (16) tick();
   endtask

   initial begin
      logic [7:0] exp_cnt;

      // clock/reset
      i_rst = 1'b1; i_loop = 1'b0; i_count_clr = 1'b0;
      repeat (3) tick();
      chk1("rst_vd", o_vd, 1'b0);
      chk1("rst_fault", o_fault, 1'b0);
      chkn("rst_cnt", o_veh_count, 8'd0);
      i_rst = 1'b0;
      tick();
      chk1("idle_vd", o_vd, 1'b0);

      // Rise latency: o_vd goes high after the 4th edge past the first high sample.
      i_loop = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk1($sformatf("rise_vd_k%0d", k), o_vd, k >= 4);
      end
      chkn("rise_cnt", o_veh_count, 8'd1);
      i_loop = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk1($sformatf("fall_vd_k%0d", k), o_vd, k < 14);
      end
      chkn("fall_cnt", o_veh_count, 8'd1);

      // Table: loop, clr, cycles, check-every-cycle, vd, fault, count
      add_vec(0, 1, 1, 0, 0, 0, 0);
      for (int g = 0; g < 3; g++) begin
         add_vec(1, 0, 2, 1, 0, 0, 0);
         add_vec(0, 0, 2, 1, 0, 0, 0);
      end
      add_vec(0, 0, 4, 1, 0, 0, 0);
      // Vehicle with a short mid-presence dropout
      add_vec(1, 0, 6, 0, 1, 0, 1);
      add_vec(0, 0, 2, 1, 1, 0, 1);
      add_vec(1, 0, 8, 1, 1, 0, 1);
      // Re-detect while in HOLD
      add_vec(0, 0, 7, 1, 1, 0, 1);
      add_vec(1, 0, 10, 1, 1, 0, 2);
      add_vec(0, 0, 16, 0, 0, 0, 2);
      // Re-detect qualifying on the exact hold-timeout cycle
      add_vec(1, 0, 10, 0, 1, 0, 3);
      add_vec(0, 0, 10, 1, 1, 0, 3);
      add_vec(1, 0, 6, 1, 1, 0, 4);
      add_vec(0, 0, 16, 0, 0, 0, 4);
      // Stuck timeout coinciding with release qualification, then exit straight to IDLE
      add_vec(1, 0, 200, 0, 1, 0, 5);
      add_vec(0, 0, 5, 0, 1, 1, 5);
      add_vec(0, 0, 2, 1, 1, 1, 5);
      add_vec(0, 0, 1, 0, 0, 0, 5);
      add_vec(0, 0, 4, 1, 0, 0, 5);

      for (int i = 0; i < vecs.size(); i++) begin
         i_loop = vecs[i].loop;
         i_count_clr = vecs[i].clr;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            tick();
            if (vecs[i].every) begin
               chk1($sformatf("vec%0d_c%0d_vd", i, c), o_vd, vecs[i].exp_vd);
               chk1($sformatf("vec%0d_c%0d_fault", i, c), o_fault, vecs[i].exp_fault);
            end
         end
         i_count_clr = 1'b0;
         chk1($sformatf("vec%0d_vd", i), o_vd, vecs[i].exp_vd);
         chk1($sformatf("vec%0d_fault", i), o_fault, vecs[i].exp_fault);
         chkn($sformatf("vec%0d_cnt", i), o_veh_count, vecs[i].exp_cnt);
      end

      // Stuck loop: fault exactly 200 edges after PRESENT entry.
      i_loop = 1'b1;
      for (int k = 0; k < 250; k++) begin
         tick();
         chk1($sformatf("stuck_fault_k%0d", k), o_fault, k >= 204);
         chk1($sformatf("stuck_vd_k%0d", k), o_vd, k >= 4);
      end
      chkn("stuck_cnt", o_veh_count, 8'd6);
      i_loop = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk1($sformatf("unstuck_fault_k%0d", k), o_fault, k < 4);
         chk1($sformatf("unstuck_vd_k%0d", k), o_vd, k < 4);
      end

      // Saturation against a running model.
      i_count_clr = 1'b1;
      tick();
      i_count_clr = 1'b0;
      chkn("clr_alone", o_veh_count, 8'd0);
      exp_cnt = 8'd0;
      for (int v = 0; v < 256; v++) begin
         vehicle();
         exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
         exp_q.push_back(exp_cnt);
         chkn($sformatf("sat_v%0d", v), o_veh_count, exp_q.pop_front());
      end
      chkn("sat_hold", o_veh_count, 8'd255);

      // Clear on the same edge as the PRESENT entry.
      i_loop = 1'b1;
      repeat (4) tick();
      chk1("clrinc_pre_vd", o_vd, 1'b0);
      i_count_clr = 1'b1;
      tick();
      i_count_clr = 1'b0;
      chkn("clrinc_cnt", o_veh_count, 8'd1);
      chk1("clrinc_vd", o_vd, 1'b1);
      repeat (3) tick();

      // Reset while in HOLD.
      i_loop = 1'b0;
      repeat (6) tick();
      chk1("hold_vd", o_vd, 1'b1);
      i_rst = 1'b1;
      tick();
      chk1("rst_hold_vd", o_vd, 1'b0);
      chkn("rst_hold_cnt", o_veh_count, 8'd0);
      chk1("rst_hold_fault", o_fault, 1'b0);
      i_rst = 1'b0;
      repeat (3) tick();
      chk1("post_rst_vd", o_vd, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
